// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: data width, NOP encoding and the fetch-queue entry.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries. The head entry is visible combinationally
// so decode sees it in the same cycle it becomes valid. Flush beats push and pop.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer and occupancy update; flush and reset empty the queue outright.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset: validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited requests to instruction
// memory, squashes responses owed to redirected-away requests and queues the rest for decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            inst_valid
);
    localparam int unsigned QW = $clog2(QDEPTH + 1);
    // Headroom for inflight + occupancy before the credit compare.
    localparam int unsigned CW = QW + 1;
    // Squashed responses can pile up across back-to-back redirects, since credit only
    // tracks live requests; the memory itself bounds how many are really outstanding.
    localparam int unsigned DW = 8;

    logic [XLEN-1:0] r_pc_next;
    logic [QW-1:0]   r_inflight;
    logic [DW-1:0]   r_discard;

    logic [QW-1:0]   w_occ;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_pop;
    logic            w_issue;
    logic            w_rsp_live;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic [CW-1:0]   w_credit_used;
    logic [XLEN-1:0] w_rsp_pc;

    // Presentation, pop and credit decisions for the current cycle.
    always_comb begin
        inst_valid = !w_empty;
        InstrF     = inst_valid ? w_head.instr : NOP_INSTR;
        PCF        = inst_valid ? w_head.pc : RESET_PC;
        PCPlus4F   = PCF + XLEN'(4);

        // Redirect outranks both stall and pop.
        w_pop = inst_valid && !StallF && !PCSrcE;

        // Credit counts entries that will still hold a slot after this cycle's pop.
        w_credit_used  = CW'(r_inflight) + CW'(w_occ) - CW'(w_pop);
        imem_req_valid = !reset && !PCSrcE && (w_credit_used < CW'(QDEPTH));
        imem_req_addr  = r_pc_next;
        w_issue        = imem_req_valid && imem_req_ready;

        // Responses arrive in order, so the oldest live request sits inflight words behind
        // pc_next; squashed requests were removed from inflight when they were squashed.
        w_rsp_live = imem_rsp_valid && (r_discard == '0);
        w_rsp_drop = imem_rsp_valid && (r_discard != '0);
        w_rsp_keep = w_rsp_live && !PCSrcE && (!w_full || w_pop);
        w_rsp_pc   = r_pc_next - (XLEN'(r_inflight) << 2);

        w_push_entry.pc    = w_rsp_pc;
        w_push_entry.instr = imem_rsp_data;
    end

    // PC, in-flight and discard bookkeeping; every counter moves by its net change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_next  <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else if (PCSrcE) begin
            // Everything still outstanding becomes owed-and-dropped, less the one arriving now.
            r_pc_next  <= align_word(PCTargetE);
            r_inflight <= '0;
            r_discard  <= r_discard + DW'(r_inflight) - DW'(imem_rsp_valid);
        end else begin
            if (w_issue) begin
                r_pc_next <= r_pc_next + XLEN'(4);
            end
            r_inflight <= r_inflight + QW'(w_issue) - QW'(w_rsp_live);
            if (w_rsp_drop) begin
                r_discard <= r_discard - DW'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (w_rsp_keep),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (PCSrcE),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_occ),
        .head       (w_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a configurable-latency in-order instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        inst_valid;

    int n_cmp = 0;
    int n_mis = 0;

    // Memory model state
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] m_exp_addr = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .inst_valid     (inst_valid)
    );

    // Accept requests and track where the next request address should be.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
                m_exp_addr = 32'h0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(cyc + lat);
                end
                if (PCSrcE) m_exp_addr = {PCTargetE[31:2], 2'b00};
                else if (imem_req_valid && imem_req_ready) m_exp_addr = m_exp_addr + 32'd4;
            end
            cyc = cyc + 1;
        end
    end

    // Return at most one response per cycle, in order, data = addr | 0x13.
    initial begin
        forever begin
            @(negedge clk);
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_addr[0] | 32'h13;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_cmp++; if (InstrF !== 32'h13) begin n_mis++; $display("FAIL reset_instr: got %h want 00000013", InstrF); end
        n_cmp++; if (PCF !== 32'h0) begin n_mis++; $display("FAIL reset_pcf: got %h want 00000000", PCF); end
        n_cmp++; if (PCPlus4F !== 32'h4) begin n_mis++; $display("FAIL reset_pcplus4: got %h want 00000004", PCPlus4F); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_mis++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_mis++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); end
    endtask

    // Cycles c0..c3 after reset release.
    task automatic test_sequential();
        @(negedge clk); reset = 1'b0; #1;  // c0
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_mis++; $display("FAIL seq_first_req: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_mis++; $display("FAIL seq_first_addr: got %h want 0", imem_req_addr); end
        @(negedge clk); #1;  // c1
        n_cmp++; if (inst_valid !== 1'b0) begin n_mis++; $display("FAIL seq_c1_valid: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req_addr !== 32'h4) begin n_mis++; $display("FAIL seq_c1_addr: got %h want 4", imem_req_addr); end
        @(negedge clk); #1;  // c2
        n_cmp++; if (inst_valid !== 1'b1) begin n_mis++; $display("FAIL seq_c2_valid: got %b want 1", inst_valid); end
        n_cmp++; if (PCF !== 32'h0) begin n_mis++; $display("FAIL seq_c2_pcf: got %h want 0", PCF); end
        n_cmp++; if (InstrF !== 32'h13) begin n_mis++; $display("FAIL seq_c2_instr: got %h want 13", InstrF); end
        n_cmp++; if (PCPlus4F !== 32'h4) begin n_mis++; $display("FAIL seq_c2_pcplus4: got %h want 4", PCPlus4F); end
        @(negedge clk); #1;  // c3
        n_cmp++; if (PCF !== 32'h4) begin n_mis++; $display("FAIL seq_c3_pcf: got %h want 4", PCF); end
        n_cmp++; if (InstrF !== 32'h17) begin n_mis++; $display("FAIL seq_c3_instr: got %h want 17", InstrF); end
    endtask

    // Cycles c4..c9: stall while PC 8 is presented.
    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin  // c4, c5, c6
            @(negedge clk); StallF = 1'b1; #1;
            n_cmp++; if (PCF !== 32'h8) begin n_mis++; $display("FAIL stall_pcf[%0d]: got %h want 8", i, PCF); end
            n_cmp++; if (InstrF !== 32'h1b) begin n_mis++; $display("FAIL stall_instr[%0d]: got %h want 1b", i, InstrF); end
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_mis++; $display("FAIL stall_no_req[%0d]: got %b want 0", i, imem_req_valid); end
        end
        @(negedge clk); StallF = 1'b0; #1;  // c7
        n_cmp++; if (PCF !== 32'h8) begin n_mis++; $display("FAIL stall_release_pcf: got %h want 8", PCF); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            n_mis++; $display("FAIL stall_release_req: got %b/%h want 1/10", imem_req_valid, imem_req_addr);
        end
        @(negedge clk); #1;  // c8
        n_cmp++; if (PCF !== 32'hc) begin n_mis++; $display("FAIL stall_resume_pcf12: got %h want c", PCF); end
        @(negedge clk); #1;  // c9
        n_cmp++; if (PCF !== 32'h10) begin n_mis++; $display("FAIL stall_resume_pcf16: got %h want 10", PCF); end
    endtask

    // c10: redirect while a response arrives and the head pops; target wraps the PC space.
    task automatic test_redirect_rsp_pop();
        @(negedge clk); PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE; #1;  // c10
        n_cmp++; if (inst_valid !== 1'b1 || PCF !== 32'h14) begin
            n_mis++; $display("FAIL rp_pre_head: got %b/%h want 1/14", inst_valid, PCF);
        end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_mis++; $display("FAIL rp_no_req: got %b want 0", imem_req_valid); end
        @(negedge clk); PCSrcE = 1'b0; #1;  // c11
        n_cmp++; if (inst_valid !== 1'b0) begin n_mis++; $display("FAIL rp_flushed: got %b want 0", inst_valid); end
        n_cmp++; if (int'(dut.r_discard) !== 0) begin n_mis++; $display("FAIL rp_discard: got %0d want 0", dut.r_discard); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            n_mis++; $display("FAIL rp_target_req: got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr);
        end
        @(negedge clk); #1;  // c12
        n_cmp++; if (inst_valid !== 1'b0) begin n_mis++; $display("FAIL rp_c12_valid: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_mis++; $display("FAIL rp_wrap_addr: got %h want 0", imem_req_addr); end
        @(negedge clk); #1;  // c13
        n_cmp++; if (PCF !== 32'hFFFF_FFFC || InstrF !== 32'hFFFF_FFFF) begin
            n_mis++; $display("FAIL rp_target_head: got %h/%h want fffffffc/ffffffff", PCF, InstrF);
        end
        n_cmp++; if (PCPlus4F !== 32'h0) begin n_mis++; $display("FAIL rp_pcplus4_wrap: got %h want 0", PCPlus4F); end
        @(negedge clk); #1;  // c14
        n_cmp++; if (PCF !== 32'h0 || InstrF !== 32'h13) begin
            n_mis++; $display("FAIL rp_wrapped_head: got %h/%h want 0/13", PCF, InstrF);
        end
    endtask

    // Fresh start with 3-cycle memory; redirect at c1 with one request in flight.
    task automatic test_redirect_inflight();
        int idx;
        bit found;
        reset = 1'b1; lat = 3; StallF = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk); reset = 1'b0; #1;  // c0
        @(negedge clk); PCSrcE = 1'b1; PCTargetE = 32'h103; #1;  // c1
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_mis++; $display("FAIL ri_no_req: got %b want 0", imem_req_valid); end
        @(negedge clk); PCSrcE = 1'b0; #1;  // c2
        n_cmp++; if (int'(dut.r_discard) !== 1) begin n_mis++; $display("FAIL ri_discard: got %0d want 1", dut.r_discard); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_mis++; $display("FAIL ri_target_req: got %b/%h want 1/100", imem_req_valid, imem_req_addr);
        end
        idx = 2; found = 1'b0;
        while (!found && idx < 20) begin
            @(negedge clk); #1; idx++;
            if (inst_valid) found = 1'b1;
        end
        n_cmp++; if (idx !== 6) begin n_mis++; $display("FAIL ri_first_valid_cycle: got c%0d want c6", idx); end
        n_cmp++; if (PCF !== 32'h100 || InstrF !== 32'h113) begin
            n_mis++; $display("FAIL ri_first_head: got %h/%h want 100/113", PCF, InstrF);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk); #1;
            if (inst_valid) found = 1'b1;
        end
        n_cmp++; if (!found || PCF !== 32'h104) begin
            n_mis++; $display("FAIL ri_second_head: got %b/%h want 1/104", found, PCF);
        end
    endtask

    // Continue with 3-cycle memory and ready toggling every cycle.
    task automatic test_latency_toggle();
        logic [31:0] exp_pc = 32'h108;
        int pops = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); imem_req_ready = ~imem_req_ready; #1;
            if (imem_req_valid) begin
                n_cmp++; if (imem_req_addr !== m_exp_addr) begin
                    n_mis++; $display("FAIL lt_req_addr[%0d]: got %h want %h", i, imem_req_addr, m_exp_addr);
                end
            end
            if (inst_valid) begin
                n_cmp++; if (PCF !== exp_pc || InstrF !== (exp_pc | 32'h13)) begin
                    n_mis++; $display("FAIL lt_head[%0d]: got %h/%h want %h/%h", i, PCF, InstrF, exp_pc,
                                      exp_pc | 32'h13);
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        imem_req_ready = 1'b1;
        n_cmp++; if (pops < 8) begin n_mis++; $display("FAIL lt_progress: got %0d pops want >=8", pops); end
    endtask

    // Fill the queue under stall, then reset mid-stream and restart.
    task automatic test_reset_mid();
        lat = 1; StallF = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (int'(dut.w_occ) !== 2 || inst_valid !== 1'b1) begin
            n_mis++; $display("FAIL rm_filled: got occ %0d valid %b want 2/1", dut.w_occ, inst_valid);
        end
        @(negedge clk); reset = 1'b1; #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_mis++; $display("FAIL rm_req_in_reset: got %b want 0", imem_req_valid); end
        @(negedge clk); #1;
        n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_mis++; $display("FAIL rm_after_reset: got %b/%b want 0/0", inst_valid, imem_req_valid);
        end
        n_cmp++; if (InstrF !== 32'h13 || PCF !== 32'h0) begin
            n_mis++; $display("FAIL rm_reset_outputs: got %h/%h want 13/0", InstrF, PCF);
        end
        @(negedge clk); reset = 1'b0; StallF = 1'b0; #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_mis++; $display("FAIL rm_restart_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr);
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || PCF !== 32'h0) begin
            n_mis++; $display("FAIL rm_restart_head: got %b/%h want 1/0", inst_valid, PCF);
        end
        @(negedge clk); #1;
        n_cmp++; if (PCF !== 32'h4 || InstrF !== 32'h17) begin
            n_mis++; $display("FAIL rm_restart_next: got %h/%h want 4/17", PCF, InstrF);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_rsp_pop();
        test_redirect_inflight();
        test_latency_toggle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
